// File: rtl/rgb_seq_pkg.sv
// Shared types and constants for the RGB PWM fade sequencer.
package rgb_seq_pkg;

  localparam int unsigned LEVEL_W = 8;

  // Colour indices follow the cmd_mask bit order {r,g,b}
  localparam int unsigned CLR_R = 2;
  localparam int unsigned CLR_G = 1;
  localparam int unsigned CLR_B = 0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } seq_state_e;

endpackage

// File: rtl/rgb_pwm_gen.sv
// Free-running 8-bit PWM counter, optional gamma mapping and registered comparators.
// Gamma mapping is enabled by defining RGB_PWM_GAMMA_EN.
module rgb_pwm_gen
  import rgb_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LEVEL_W-1:0] level_i,
  input  logic [2:0]         mask_i,
  output logic               pwm_r_o,
  output logic               pwm_g_o,
  output logic               pwm_b_o
);

  logic [LEVEL_W-1:0] pwm_cnt_q;
  logic [LEVEL_W-1:0] level_eff_c;

`ifdef RGB_PWM_GAMMA_EN
  logic [2*LEVEL_W-1:0] sq_c;
  // Square law keeps low levels perceptually dim
  assign sq_c        = {{LEVEL_W{1'b0}}, level_i} * {{LEVEL_W{1'b0}}, level_i};
  assign level_eff_c = LEVEL_W'(sq_c >> LEVEL_W);
`else
  assign level_eff_c = level_i;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      pwm_r_o   <= 1'b0;
      pwm_g_o   <= 1'b0;
      pwm_b_o   <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + LEVEL_W'(1);
      pwm_r_o   <= mask_i[CLR_R] && (pwm_cnt_q < level_eff_c);
      pwm_g_o   <= mask_i[CLR_G] && (pwm_cnt_q < level_eff_c);
      pwm_b_o   <= mask_i[CLR_B] && (pwm_cnt_q < level_eff_c);
    end
  end

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// Fade-command sequencer: ramp up to peak, hold, ramp down; drives SB_RGBA_DRV PWM inputs.
// Optional gamma mapping in rgb_pwm_gen via RGB_PWM_GAMMA_EN.
module rgb_pwm_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int unsigned STEP_DIV   = 11719,
  parameter int unsigned HOLD_STEPS = 256
) (
  input  logic               int_osc,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_mask,
  input  logic [LEVEL_W-1:0] cmd_peak,
  input  logic               abort,
  output logic               pwm_r,
  output logic               pwm_g,
  output logic               pwm_b,
  output logic               busy,
  output logic               done
);

  localparam int unsigned PRE_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_STEPS + 1);

  seq_state_e         state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LEVEL_W-1:0] peak_q, peak_d;
  logic [2:0]         mask_q, mask_d;
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               done_q, done_d;
  logic               zpend_q, zpend_d;
  logic               ready_q, busy_q;
  logic               step_c;

  assign step_c = (presc_q == PRE_W'(STEP_DIV - 1));

  always_ff @(posedge int_osc) begin
    if (!rst_n) begin
      state_q <= IDLE;
      level_q <= '0;
      peak_q  <= '0;
      mask_q  <= '0;
      presc_q <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
      zpend_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      peak_q  <= peak_d;
      mask_q  <= mask_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      zpend_q <= zpend_d;
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
    end
  end

  // Next-state and datapath; abort wins over a coincident step
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    peak_d  = peak_q;
    mask_d  = mask_q;
    hold_d  = hold_q;
    presc_d = step_c ? '0 : presc_q + PRE_W'(1);
    zpend_d = 1'b0;
    done_d  = zpend_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && ready_q) begin
          mask_d  = cmd_mask;
          peak_d  = cmd_peak;
          level_d = '0;
          presc_d = '0;
          if (cmd_peak == '0) zpend_d = 1'b1;
          else                state_d = RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (abort) begin
          state_d = RAMP_DOWN;
        end else if (step_c) begin
          level_d = level_q + LEVEL_W'(1);
          if (level_q + LEVEL_W'(1) == peak_q) begin
            state_d = HOLD;
            hold_d  = '0;
          end
        end
      end
      HOLD: begin
        if (abort) begin
          state_d = RAMP_DOWN;
        end else if (step_c) begin
          hold_d = hold_q + HOLD_W'(1);
          if (hold_d == HOLD_W'(HOLD_STEPS)) state_d = RAMP_DOWN;
        end
      end
      RAMP_DOWN: begin
        if (step_c) begin
          if (level_q <= LEVEL_W'(1)) begin
            level_d = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            level_d = level_q - LEVEL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

  rgb_pwm_gen u_pwm_gen (
    .clk     (int_osc),
    .rst_n   (rst_n),
    .level_i (level_q),
    .mask_i  (mask_q),
    .pwm_r_o (pwm_r),
    .pwm_g_o (pwm_g),
    .pwm_b_o (pwm_b)
  );

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Directed bench for rgb_pwm_sequencer with STEP_DIV=4, HOLD_STEPS=2 (plus a long-hold duty instance).
module tb_rgb_pwm_sequencer;
  import rgb_seq_pkg::*;

`ifdef RGB_PWM_GAMMA_EN
  localparam int DUTY_EXP = 0;
`else
  localparam int DUTY_EXP = 3;
`endif

  logic       int_osc = 1'b0;
  logic       rst_n, cmd_valid, abort;
  logic [2:0] cmd_mask;
  logic [7:0] cmd_peak;
  logic       cmd_ready, pwm_r, pwm_g, pwm_b, busy, done;

  logic       d_valid, d_abort;
  logic [2:0] d_mask;
  logic [7:0] d_peak;
  logic       d_ready, d_pwm_r, d_pwm_g, d_pwm_b, d_busy, d_done;

  int n_vec = 0;
  int n_err = 0;

  always #5 int_osc = ~int_osc;

  rgb_pwm_sequencer #(.STEP_DIV(4), .HOLD_STEPS(2)) dut (
    .int_osc(int_osc), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mask(cmd_mask), .cmd_peak(cmd_peak), .abort(abort),
    .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b), .busy(busy), .done(done)
  );

  // Long hold so level 3 is stable across a full 256-cycle PWM period
  rgb_pwm_sequencer #(.STEP_DIV(4), .HOLD_STEPS(128)) dut_d (
    .int_osc(int_osc), .rst_n(rst_n), .cmd_valid(d_valid), .cmd_ready(d_ready),
    .cmd_mask(d_mask), .cmd_peak(d_peak), .abort(d_abort),
    .pwm_r(d_pwm_r), .pwm_g(d_pwm_g), .pwm_b(d_pwm_b), .busy(d_busy), .done(d_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle 0 (acceptance edge)
  task automatic send(input logic [2:0] m, input logic [7:0] p);
    cmd_mask  = m;
    cmd_peak  = p;
    cmd_valid = 1'b1;
    @(posedge int_osc);
    @(negedge int_osc);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int dcnt, dcyc, hits, ghits, idle_cnt, found;
    logic gb;
    rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0; cmd_mask = '0; cmd_peak = '0;
    d_valid = 1'b0; d_abort = 1'b0; d_mask = '0; d_peak = '0;

    // Reset
    repeat (3) @(negedge int_osc);
    chk("rst_ready_low", 32'(cmd_ready), 0);
    chk("rst_level", 32'(dut.level_q), 0);
    rst_n = 1'b1;
    @(negedge int_osc);
    chk("rst_pwm", {29'd0, pwm_r, pwm_g, pwm_b}, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ready", 32'(cmd_ready), 1);

    // Full sequence, peak 3, red only
    send(3'b100, 8'd3);
    chk("seq_c0_ready", 32'(cmd_ready), 0);
    chk("seq_c0_busy", 32'(busy), 1);
    gb = 1'b0; dcnt = 0; dcyc = -1;
    for (int c = 1; c <= 36; c++) begin
      @(negedge int_osc);
      if (pwm_g || pwm_b) gb = 1'b1;
      if (done) begin dcnt++; dcyc = c; end
      case (c)
        3:  chk("seq_lvl_c3", 32'(dut.level_q), 0);
        4:  chk("seq_lvl_c4", 32'(dut.level_q), 1);
        8:  chk("seq_lvl_c8", 32'(dut.level_q), 2);
        12: chk("seq_lvl_c12", 32'(dut.level_q), 3);
        19: chk("seq_hold_c19", 32'(dut.state_q), 32'(HOLD));
        23: chk("seq_lvl_c23", 32'(dut.level_q), 3);
        24: chk("seq_lvl_c24", 32'(dut.level_q), 2);
        28: chk("seq_lvl_c28", 32'(dut.level_q), 1);
        32: begin
          chk("seq_lvl_c32", 32'(dut.level_q), 0);
          chk("seq_ready_c32", 32'(cmd_ready), 1);
        end
        default: ;
      endcase
    end
    chk("seq_done_cycle", 32'(dcyc), 32);
    chk("seq_done_count", 32'(dcnt), 1);
    chk("seq_gb_low", 32'(gb), 0);

    // Duty cycle at level 3 over one PWM period
    d_mask = 3'b100; d_peak = 8'd3; d_valid = 1'b1;
    @(posedge int_osc);
    @(negedge int_osc);
    d_valid = 1'b0;
    repeat (19) @(negedge int_osc);
    hits = 0; ghits = 0;
    for (int c = 0; c < 256; c++) begin
      @(negedge int_osc);
      if (d_pwm_r) hits++;
      if (d_pwm_g || d_pwm_b) ghits++;
    end
    chk("duty_r_high", 32'(hits), 32'(DUTY_EXP));
    chk("duty_gb_high", 32'(ghits), 0);
    chk("duty_level", 32'(dut_d.level_q), 3);
    found = 0;
    for (int c = 0; c < 700 && found == 0; c++) begin
      @(negedge int_osc);
      if (d_done) found = 1;
    end
    chk("duty_done_seen", 32'(found), 1);

    // Abort during ramp-up at level 3
    send(3'b111, 8'd10);
    repeat (12) @(negedge int_osc);
    chk("abort_lvl_c12", 32'(dut.level_q), 3);
    @(negedge int_osc);
    abort = 1'b1;
    @(negedge int_osc);
    abort = 1'b0;
    chk("abort_state_c14", 32'(dut.state_q), 32'(RAMP_DOWN));
    chk("abort_lvl_c14", 32'(dut.level_q), 3);
    dcyc = -1;
    for (int c = 15; c <= 30; c++) begin
      @(negedge int_osc);
      if (done) dcyc = c;
      if (c == 16) chk("abort_lvl_c16", 32'(dut.level_q), 2);
      if (c == 20) chk("abort_lvl_c20", 32'(dut.level_q), 1);
    end
    chk("abort_done_cycle", 32'(dcyc), 24);

    // Peak zero: done one cycle after acceptance, no activity
    send(3'b111, 8'd0);
    chk("p0_done_c0", 32'(done), 0);
    chk("p0_busy_c0", 32'(busy), 0);
    @(negedge int_osc);
    chk("p0_done_c1", 32'(done), 1);
    @(negedge int_osc);
    chk("p0_done_c2", 32'(done), 0);
    gb = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge int_osc);
      if (pwm_r || pwm_g || pwm_b || busy) gb = 1'b1;
    end
    chk("p0_quiet", 32'(gb), 0);
    chk("p0_ready", 32'(cmd_ready), 1);

    // cmd_valid held through a sequence: next acceptance only in done cycle
    cmd_mask = 3'b010; cmd_peak = 8'd1; cmd_valid = 1'b1;
    @(posedge int_osc);
    @(negedge int_osc);
    idle_cnt = 0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge int_osc);
      if (c <= 16 && !busy) idle_cnt++;
      if (c == 16) begin
        chk("held_done_c16", 32'(done), 1);
        chk("held_ready_c16", 32'(cmd_ready), 1);
      end
      if (c == 17) chk("held_busy_c17", 32'(busy), 1);
    end
    cmd_valid = 1'b0;
    chk("held_idle_cycles", 32'(idle_cnt), 1);
    dcyc = -1;
    for (int c = 18; c <= 40; c++) begin
      @(negedge int_osc);
      if (done && dcyc < 0) dcyc = c;
    end
    chk("held_second_done", 32'(dcyc), 33);

    // Reset during HOLD
    send(3'b111, 8'd2);
    repeat (10) @(negedge int_osc);
    chk("mrst_state_c10", 32'(dut.state_q), 32'(HOLD));
    rst_n = 1'b0;
    @(negedge int_osc);
    chk("mrst_level", 32'(dut.level_q), 0);
    chk("mrst_pwm", {29'd0, pwm_r, pwm_g, pwm_b}, 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_ready", 32'(cmd_ready), 0);
    rst_n = 1'b1;
    @(negedge int_osc);
    chk("mrst_ready_after", 32'(cmd_ready), 1);
    dcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge int_osc);
      if (done) dcnt++;
    end
    chk("mrst_no_done", 32'(dcnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rgb_pwm_sequencer.md
# rgb_pwm_sequencer

Upstream PWM source for the iCE40 `SB_RGBA_DRV` LED driver. It accepts fade commands over a valid/ready handshake. For each accepted command it produces three PWM streams that ramp linearly from zero to a commanded peak brightness, hold, and ramp back to zero. The block runs on the `SB_HFOSC` clock, and its outputs connect directly to the driver's `RGBnPWM` inputs: `pwm_g`→`RGB0PWM`, `pwm_b`→`RGB1PWM`, `pwm_r`→`RGB2PWM`.

## Interface
- `STEP_DIV`, default 11719: clocks per brightness step. The default gives about 0.5 s per full ramp at 6 MHz.
- `HOLD_STEPS`, default 256: number of step ticks spent at peak brightness.
- `int_osc` input, 1 bit: clock from `SB_HFOSC`.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `cmd_valid` input, 1 bit: a command is offered.
- `cmd_ready` output, 1 bit: the block can accept a command (state IDLE).
- `cmd_mask` input, 3 bits: colour enables, ordered {r,g,b}.
- `cmd_peak` input, 8 bits: target brightness level.
- `abort` input, 1 bit: begin ramp-down immediately.
- `pwm_r`, `pwm_g`, `pwm_b` outputs, 1 bit each: registered PWM streams.
- `busy` output, 1 bit: state is not IDLE.
- `done` output, 1 bit: one-cycle pulse when a sequence ends.

## Operation
- **Reset values** (one `int_osc` edge with `rst_n`=0):
  - state = IDLE, `level` = 0, `pwm_cnt` = 0, prescaler = 0.
  - `pwm_*` = 0, `busy` = 0, `done` = 0.
  - `cmd_ready` = 0 while `rst_n` is low, then 1.
- **PWM counter:** 8-bit free-running `pwm_cnt`, increments every clock and wraps 255→0.
- **PWM output:** `pwm_x` <= `mask[x]` && (`pwm_cnt` < `level_eff`).
  - `level_eff` = 0 gives output always low.
  - `level_eff` = 255 gives 255 high cycles out of every 256.
- **Step tick:** prescaler counts 0..`STEP_DIV`-1. It raises `step` when it wraps and is cleared on command acceptance.
- **FSM states:** IDLE, RAMP_UP, HOLD, RAMP_DOWN.
  - **IDLE**, on `cmd_valid` && `cmd_ready`: latch mask and peak, set `level` = 0. Go to RAMP_UP, or if peak = 0, stay in IDLE and pulse `done` on the next cycle.
  - **RAMP_UP:** `level`++ on each `step`. When `level` reaches peak, go to HOLD and clear the hold counter.
  - **HOLD:** count `step` ticks. On `HOLD_STEPS`, go to RAMP_DOWN.
  - **RAMP_DOWN:** `level`-- on each `step`. On the edge where `level` becomes 0, go to IDLE and set `done`=1 for one cycle.
- **Abort:** `abort`=1 in RAMP_UP or HOLD forces RAMP_DOWN on the next edge, from the current `level`. `abort` has no effect in IDLE or RAMP_DOWN.
- **Command protocol:** `cmd_valid` is ignored while `busy`. No queueing: a command is taken only when `cmd_ready`=1.
- **Zero mask:** `cmd_mask` = 0 runs the full timing with all outputs low.
- **Level arithmetic:** `level` is 8 bits and never wraps. It is bounded by peak on the way up and by 0 on the way down.
- **Reset mid-sequence:** returns to IDLE immediately, with outputs low on the next cycle. No `done` pulse is produced.

## Timing
- Command acceptance edge = cycle 0. The first `step` occurs at cycle `STEP_DIV`.
- Sequence length: `done` is high in cycle (2·peak + `HOLD_STEPS`)·`STEP_DIV`, and `cmd_ready` is high in that same cycle.
- A new command accepted in the `done` cycle is legal (back-to-back).
- PWM latency: `pwm_*` reflects `level_eff` and `pwm_cnt` one clock after they change.
- PWM period is 256 clocks, about 23.4 kHz at 6 MHz.

## Configuration
- `RGB_PWM_GAMMA_EN` defined:
  - `level_eff` = (`level`·`level`) >> 8, computed as a 16-bit product.
  - Examples: 255→254, 128→64, 15→0.
- `RGB_PWM_GAMMA_EN` undefined: `level_eff` = `level`.
- FSM timing is identical in both builds.

## Structure
- Package `rgb_seq_pkg` holds:
  - the FSM state enum (IDLE, RAMP_UP, HOLD, RAMP_DOWN);
  - `LEVEL_W` = 8;
  - colour index constants R=2, G=1, B=0, which match the `cmd_mask` bit order.
- Sub-module `rgb_pwm_gen` contains `pwm_cnt`, the optional gamma mapping and the three registered comparators. Its inputs are `level` and `mask`.

## Test plan
All scenarios use `STEP_DIV`=4 and `HOLD_STEPS`=2.
- **Reset:** hold `rst_n`=0 for 3 cycles. `pwm_*`=0, `busy`=0, `done`=0, and `cmd_ready`=1 on the first cycle after release.
- **Full sequence:** mask=3'b100, peak=3.
  - `level` reads 1, 2, 3 at cycles 4, 8, 12; HOLD lasts until cycle 20.
  - `level` reads 2, 1, 0 at cycles 24, 28, 32; `done` is high only in cycle 32.
  - `pwm_g` and `pwm_b` stay 0 throughout.
- **Duty cycle:** hold `level`=3, no gamma. `pwm_r` is high for exactly 3 of every 256 cycles. With `RGB_PWM_GAMMA_EN`, `pwm_r` is high for 0 of every 256 cycles.
- **Abort:** peak=10, assert `abort` at cycle 13 (`level`=3). RAMP_DOWN starts on the next edge and `done` arrives after 3 more steps.
- **Edge commands:**
  - peak=0: `done` one cycle after acceptance, outputs always 0.
  - `cmd_valid` held high during `busy`: no second acceptance until the `done` cycle.
- **Reset mid-HOLD:** assert `rst_n`=0 during HOLD. `level`=0 and outputs low the next cycle, and no `done` pulse.
